alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Hardwired control unit that sequences the existing datapath through instruction fetch and execution of three-register ALU instructions (add, sub, and, or, shifts, rotates, and so on).
- Each state drives one control step, T0–T5: PC/MAR/IR control, register-file Rin/Rout strobes, Y/Z enables and ALUop.
- Connects directly to the datapath control inputs and reads the IR contents back from the datapath.
- Replaces hand-written per-instruction testbench state machines.

Parameters:
- READ_WAIT, default 0: extra cycles T1 is held, with Read and MDRin asserted, for slower memory (range 0–7).
- NUM_ALU_OPS, default 11: opcodes 0..NUM_ALU_OPS-1 are legal ALU R-format instructions.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = continuous fetch/execute, 0 = single-instruction step.
- start  in  1  pulse; leaves IDLE to begin a fetch.
- IR  in  32  datapath IR register value.
  - IR[31:27] opcode, IR[26:23] Ra (destination), IR[22:19] Rb, IR[18:15] Rc.
- PCout, MARin, IncPC, PCin  out  1 each  PC/MAR control.
- Read, MDRin, MDRout  out  1 each  memory/MDR control.
- IRin, Yin, Zlowin, Zlowout  out  1 each  IR, Y and Z control.
- Rin  out  16  one-hot register write enable.
- Rout  out  16  one-hot register bus drive.
- ALUop  out  4  ALU operation select.
- busy  out  1  high in every state except IDLE and HALTED.
- done  out  1  one-cycle pulse in T5.
- illegal  out  1  sticky; set on an unsupported opcode, cleared by clear or by start.
- halted  out  1  high in HALTED.

Behaviour:
- Reset:
  - clear=1 at a rising edge forces state IDLE, the wait counter to 0 and illegal to 0. This takes priority over every other input, including mid-instruction.
  - All outputs are 0 in IDLE.
- Output style:
  - Moore decode of the state register; outputs are combinational from state and IR only.
  - Any signal not listed for a state is 0.
  - Rin and Rout are never non-zero outside T3–T5.
- States and outputs:
  - IDLE: all outputs 0. Goes to T0 when start=1.
  - T0: PCout, MARin, IncPC, Zlowin. Goes to T1.
  - T1: Zlowout, PCin, Read, MDRin.
    - Held 1+READ_WAIT cycles using the wait counter.
    - PCin asserts only in the final T1 cycle, so PC increments exactly once.
    - Goes to T2.
  - T2: MDRout, IRin. Goes to T3.
  - T3 (decodes IR, now valid):
    - opcode = 5'd31: go to HALTED; no outputs asserted in T3.
    - opcode >= NUM_ALU_OPS and != 31: set illegal; go to T0 if run, otherwise IDLE; no register strobes.
    - Otherwise: Rout[Rb], Yin; go to T4.
  - T4: Rout[Rc], Zlowin, ALUop = opcode[3:0]. Goes to T5.
  - T5: Zlowout, Rin[Ra], done. Goes to T0 if run=1 (sampled in T5), otherwise IDLE.
  - HALTED: halted=1, all other outputs 0. Left only by clear.
- Cycle count: one instruction takes 6+READ_WAIT cycles from T0 to T5 inclusive.
- Boundary cases:
  - start is ignored while busy.
  - start and clear together: clear wins.
  - Ra = Rb = Rc is legal; each strobe is issued in its own state.
  - R0 is treated like any other register.

Test Plan:
- Reset and single step:
  - Stimulus: clear for 1 cycle, then start=1 for 1 cycle with run=0, IR=32'h43820000 (ror R7,R0,R4).
  - Required: states T0..T5 in 6 cycles; T3 Rout=16'h0001, Yin=1; T4 Rout=16'h0010, ALUop=4'd8, Zlowin=1; T5 Rin=16'h0080, done=1; then IDLE with all outputs 0.
- Continuous run:
  - Stimulus: run=1, IR alternating between opcode 0 (Ra=1, Rb=2, Rc=3) and opcode 8.
  - Required: T5 is followed directly by T0; done pulses every 6 cycles; ALUop is 0 then 8.
- READ_WAIT=2:
  - Required: Read=1 for 3 consecutive cycles; PCin=1 only in the third; instruction takes 8 cycles.
- Illegal and halt opcodes:
  - Stimulus: IR opcode 5'd20, then IR opcode 5'd31.
  - Required, opcode 20: illegal=1 after T3, no Rin/Rout activity.
  - Required, opcode 31: halted=1 held; start ignored until clear.
- Mid-instruction reset:
  - Stimulus: clear=1 during T4.
  - Required: next cycle IDLE, Rin=0, done never asserted; busy=0, illegal=0.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute control unit for three-register ALU instructions.
// Moore outputs decode the state register and the IR fields fed back from the datapath.
module alu_instr_sequencer #(
  parameter int unsigned READ_WAIT   = 0,
  parameter int unsigned NUM_ALU_OPS = 11
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        start,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [3:0]  ALUop,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        halted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_T0     = 3'd1;
  localparam logic [2:0] S_T1     = 3'd2;
  localparam logic [2:0] S_T2     = 3'd3;
  localparam logic [2:0] S_T3     = 3'd4;
  localparam logic [2:0] S_T4     = 3'd5;
  localparam logic [2:0] S_T5     = 3'd6;
  localparam logic [2:0] S_HALTED = 3'd7;

  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);
  localparam logic [4:0] OP_HALT   = 5'd31;

  logic [2:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       op_illegal;

  assign opcode     = IR[31:27];
  assign ra         = IR[26:23];
  assign rb         = IR[22:19];
  assign rc         = IR[18:15];
  assign op_illegal = ({27'd0, opcode} >= 32'(NUM_ALU_OPS)) && (opcode != OP_HALT);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_T0;
          illegal_d = 1'b0;
        end
      end
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      // T1 is stretched by READ_WAIT cycles for slow memory
      S_T1: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_T2;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALTED;
        end else if (op_illegal) begin
          illegal_d = 1'b1;
          state_d   = run ? S_T0 : S_IDLE;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:     state_d = S_T5;
      S_T5:     state_d = run ? S_T0 : S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zlowin  = 1'b0;
    Zlowout = 1'b0;
    Rin     = '0;
    Rout    = '0;
    ALUop   = '0;
    done    = 1'b0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      // PC is loaded only on the last T1 cycle so it advances once per fetch
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = (wait_q == WAIT_LAST);
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if ((opcode != OP_HALT) && !op_illegal) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Rout   = 16'h0001 << rc;
        Zlowin = 1'b1;
        ALUop  = opcode[3:0];
      end
      S_T5: begin
        Zlowout = 1'b1;
        Rin     = 16'h0001 << ra;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted  = (state_q == S_HALTED);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: one instance with default timing, one with READ_WAIT=2.
module tb_alu_instr_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run   = 1'b0;
  logic        start = 1'b0;
  logic [31:0] IR    = '0;

  logic a_PCout, a_MARin, a_IncPC, a_PCin, a_Read, a_MDRin, a_MDRout, a_IRin;
  logic a_Yin, a_Zlowin, a_Zlowout, a_busy, a_done, a_illegal, a_halted;
  logic [15:0] a_Rin, a_Rout;
  logic [3:0]  a_ALUop;

  logic b_PCout, b_MARin, b_IncPC, b_PCin, b_Read, b_MDRin, b_MDRout, b_IRin;
  logic b_Yin, b_Zlowin, b_Zlowout, b_busy, b_done, b_illegal, b_halted;
  logic [15:0] b_Rin, b_Rout;
  logic [3:0]  b_ALUop;

  logic [50:0] a_vec, b_vec;

  int checks = 0;
  int fails  = 0;

  localparam logic [14:0] F_PCOUT = 15'h4000;
  localparam logic [14:0] F_MARIN = 15'h2000;
  localparam logic [14:0] F_INCPC = 15'h1000;
  localparam logic [14:0] F_PCIN  = 15'h0800;
  localparam logic [14:0] F_READ  = 15'h0400;
  localparam logic [14:0] F_MDRIN = 15'h0200;
  localparam logic [14:0] F_MDROUT= 15'h0100;
  localparam logic [14:0] F_IRIN  = 15'h0080;
  localparam logic [14:0] F_YIN   = 15'h0040;
  localparam logic [14:0] F_ZIN   = 15'h0020;
  localparam logic [14:0] F_ZOUT  = 15'h0010;
  localparam logic [14:0] F_BUSY  = 15'h0008;
  localparam logic [14:0] F_DONE  = 15'h0004;
  localparam logic [14:0] F_ILL   = 15'h0002;
  localparam logic [14:0] F_HALT  = 15'h0001;

  localparam logic [14:0] T0_F = F_PCOUT | F_MARIN | F_INCPC | F_ZIN | F_BUSY;
  localparam logic [14:0] T1_F = F_ZOUT | F_READ | F_MDRIN | F_BUSY;
  localparam logic [14:0] T2_F = F_MDROUT | F_IRIN | F_BUSY;

  alu_instr_sequencer dut_a (
    .clock(clock), .clear(clear), .run(run), .start(start), .IR(IR),
    .PCout(a_PCout), .MARin(a_MARin), .IncPC(a_IncPC), .PCin(a_PCin),
    .Read(a_Read), .MDRin(a_MDRin), .MDRout(a_MDRout), .IRin(a_IRin),
    .Yin(a_Yin), .Zlowin(a_Zlowin), .Zlowout(a_Zlowout),
    .Rin(a_Rin), .Rout(a_Rout), .ALUop(a_ALUop),
    .busy(a_busy), .done(a_done), .illegal(a_illegal), .halted(a_halted)
  );

  alu_instr_sequencer #(.READ_WAIT(2), .NUM_ALU_OPS(11)) dut_b (
    .clock(clock), .clear(clear), .run(run), .start(start), .IR(IR),
    .PCout(b_PCout), .MARin(b_MARin), .IncPC(b_IncPC), .PCin(b_PCin),
    .Read(b_Read), .MDRin(b_MDRin), .MDRout(b_MDRout), .IRin(b_IRin),
    .Yin(b_Yin), .Zlowin(b_Zlowin), .Zlowout(b_Zlowout),
    .Rin(b_Rin), .Rout(b_Rout), .ALUop(b_ALUop),
    .busy(b_busy), .done(b_done), .illegal(b_illegal), .halted(b_halted)
  );

  assign a_vec = {a_PCout, a_MARin, a_IncPC, a_PCin, a_Read, a_MDRin, a_MDRout, a_IRin,
                  a_Yin, a_Zlowin, a_Zlowout, a_busy, a_done, a_illegal, a_halted,
                  a_Rin, a_Rout, a_ALUop};
  assign b_vec = {b_PCout, b_MARin, b_IncPC, b_PCin, b_Read, b_MDRin, b_MDRout, b_IRin,
                  b_Yin, b_Zlowin, b_Zlowout, b_busy, b_done, b_illegal, b_halted,
                  b_Rin, b_Rout, b_ALUop};

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    start = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (a_vec !== 51'd0) begin
      fails++;
      $display("FAIL reset_a: got %h expected %h", a_vec, 51'd0);
    end
    checks++;
    if (b_vec !== 51'd0) begin
      fails++;
      $display("FAIL reset_b: got %h expected %h", b_vec, 51'd0);
    end
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (a_vec !== 51'd0) begin
      fails++;
      $display("FAIL clear_beats_start: got %h expected %h", a_vec, 51'd0);
    end
  endtask

  task automatic test_single_step();
    logic [50:0] tbl [7];
    tbl[0] = {T0_F, 16'h0000, 16'h0000, 4'h0};
    tbl[1] = {T1_F | F_PCIN, 16'h0000, 16'h0000, 4'h0};
    tbl[2] = {T2_F, 16'h0000, 16'h0000, 4'h0};
    tbl[3] = {F_YIN | F_BUSY, 16'h0000, 16'h0001, 4'h0};
    tbl[4] = {F_ZIN | F_BUSY, 16'h0000, 16'h0010, 4'h8};
    tbl[5] = {F_ZOUT | F_DONE | F_BUSY, 16'h0080, 16'h0000, 4'h0};
    tbl[6] = 51'd0;
    do_clear();
    run   = 1'b0;
    IR    = 32'h43820000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (a_vec !== tbl[c]) begin
        fails++;
        $display("FAIL single_step cyc%0d: got %h expected %h", c, a_vec, tbl[c]);
      end
      tick();
    end
  endtask

  task automatic test_continuous();
    logic [31:0] instr [4];
    logic [50:0] exp;
    instr[0] = {5'd0, 4'd1, 4'd2, 4'd3, 15'd0};
    instr[1] = {5'd8, 4'd1, 4'd2, 4'd3, 15'd0};
    instr[2] = instr[0];
    instr[3] = instr[1];
    do_clear();
    run   = 1'b1;
    IR    = instr[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 6; c++) begin
        case (c)
          0:       exp = {T0_F, 16'h0000, 16'h0000, 4'h0};
          1:       exp = {T1_F | F_PCIN, 16'h0000, 16'h0000, 4'h0};
          2:       exp = {T2_F, 16'h0000, 16'h0000, 4'h0};
          3:       exp = {F_YIN | F_BUSY, 16'h0000, 16'h0004, 4'h0};
          4:       exp = {F_ZIN | F_BUSY, 16'h0000, 16'h0008, (i % 2 == 1) ? 4'h8 : 4'h0};
          default: exp = {F_ZOUT | F_DONE | F_BUSY, 16'h0002, 16'h0000, 4'h0};
        endcase
        checks++;
        if (a_vec !== exp) begin
          fails++;
          $display("FAIL continuous instr%0d cyc%0d: got %h expected %h", i, c, a_vec, exp);
        end
        if (c == 5) begin
          if (i < 3) IR = instr[i+1];
          if (i == 3) run = 1'b0;
        end
        tick();
      end
    end
    checks++;
    if (a_vec !== 51'd0) begin
      fails++;
      $display("FAIL continuous_end_idle: got %h expected %h", a_vec, 51'd0);
    end
  endtask

  task automatic test_read_wait();
    logic [50:0] tbl [9];
    tbl[0] = {T0_F, 16'h0000, 16'h0000, 4'h0};
    tbl[1] = {T1_F, 16'h0000, 16'h0000, 4'h0};
    tbl[2] = {T1_F, 16'h0000, 16'h0000, 4'h0};
    tbl[3] = {T1_F | F_PCIN, 16'h0000, 16'h0000, 4'h0};
    tbl[4] = {T2_F, 16'h0000, 16'h0000, 4'h0};
    tbl[5] = {F_YIN | F_BUSY, 16'h0000, 16'h0001, 4'h0};
    tbl[6] = {F_ZIN | F_BUSY, 16'h0000, 16'h0010, 4'h8};
    tbl[7] = {F_ZOUT | F_DONE | F_BUSY, 16'h0080, 16'h0000, 4'h0};
    tbl[8] = 51'd0;
    do_clear();
    run   = 1'b0;
    IR    = 32'h43820000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (b_vec !== tbl[c]) begin
        fails++;
        $display("FAIL read_wait cyc%0d: got %h expected %h", c, b_vec, tbl[c]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    do_clear();
    run   = 1'b0;
    IR    = {5'd20, 4'd1, 4'd2, 4'd3, 15'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (a_vec !== {F_BUSY, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL illegal_t3: got %h expected %h", a_vec, {F_BUSY, 36'd0});
    end
    tick();
    checks++;
    if (a_vec !== {F_ILL, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL illegal_sticky: got %h expected %h", a_vec, {F_ILL, 36'd0});
    end
    tick();
    checks++;
    if (a_vec !== {F_ILL, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL illegal_held: got %h expected %h", a_vec, {F_ILL, 36'd0});
    end
    IR    = 32'h43820000;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (a_vec !== {T0_F, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL illegal_cleared_by_start: got %h expected %h", a_vec, {T0_F, 36'd0});
    end
  endtask

  task automatic test_halt();
    do_clear();
    run   = 1'b0;
    IR    = {5'd31, 27'd0};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (a_vec !== {F_BUSY, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL halt_t3: got %h expected %h", a_vec, {F_BUSY, 36'd0});
    end
    tick();
    checks++;
    if (a_vec !== {F_HALT, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL halt_enter: got %h expected %h", a_vec, {F_HALT, 36'd0});
    end
    start = 1'b1;
    run   = 1'b1;
    tick();
    tick();
    start = 1'b0;
    run   = 1'b0;
    checks++;
    if (a_vec !== {F_HALT, 16'h0000, 16'h0000, 4'h0}) begin
      fails++;
      $display("FAIL halt_ignores_start: got %h expected %h", a_vec, {F_HALT, 36'd0});
    end
    do_clear();
    checks++;
    if (a_vec !== 51'd0) begin
      fails++;
      $display("FAIL halt_cleared: got %h expected %h", a_vec, 51'd0);
    end
  endtask

  task automatic test_mid_reset();
    do_clear();
    run   = 1'b1;
    IR    = 32'h43820000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (a_vec !== {F_ZIN | F_BUSY, 16'h0000, 16'h0010, 4'h8}) begin
      fails++;
      $display("FAIL mid_reset_in_t4: got %h expected %h", a_vec, {F_ZIN | F_BUSY, 16'h0000, 16'h0010, 4'h8});
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (a_vec !== 51'd0) begin
        fails++;
        $display("FAIL mid_reset_idle cyc%0d: got %h expected %h", c, a_vec, 51'd0);
      end
      tick();
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_continuous();
    test_read_wait();
    test_illegal();
    test_halt();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
